hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

- Pipeline hazard controller for the 5-stage MIPS core.
- Function:
  - detects load-use hazards, branch redirects and multi-cycle mult/div occupancy of EX;
  - drives stall/flush controls for PC, IF/ID, ID/EX and EX/MEM registers;
  - produces EX-stage operand forwarding selects.
- The ID/EX pipeline register gains Stall (hold) and Flush (zero all control bits) inputs driven from this block.

## Interface

Parameters:
- MDU_LATENCY, 4, cycles a mult/div occupies EX, including its first cycle; legal range 2..16.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- RsD, RtD  in  5  source registers of the instruction in ID.
- UsesRsD, UsesRtD  in  1  ID instruction actually reads Rs/Rt.
- RsE, RtE  in  5  source registers of the instruction in EX.
- WriteRegE  in  5  destination register of the EX instruction.
- MemReadE, RegWriteE  in  1  EX instruction is a load / writes a register.
- WriteRegM  in  5  MEM-stage destination.
- RegWriteM  in  1  MEM-stage register write enable.
- WriteRegW  in  5  WB-stage destination.
- RegWriteW  in  1  WB-stage register write enable.
- BranchTakenE  in  1  branch/jump resolved taken in EX.
- MulDivStartE  in  1  EX instruction is mult/div.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  bubble ID/EX.
- FlushM  out  1  bubble EX/MEM.
- ForwardAE, ForwardBE  out  2  ALU operand A/B select: 00 register file, 01 WB result, 10 MEM result.
- MduBusy  out  1  mult/div stall in progress.

## Operation

- State machine: IDLE, BUSY. A 4-bit down-counter Count is used in BUSY.
- Outputs are combinational from state, Count and inputs.
- Priority, highest first:
  1. Rst.
  2. MDU stall.
  3. Branch flush.
  4. Load-use stall.
- MDU stall:
  - Applies when state is BUSY with Count != 0, or state is IDLE with MulDivStartE=1.
  - Drives StallF=StallD=StallE=1 and FlushM=1; MduBusy=1.
  - FlushE=0 and FlushD=0; load-use and BranchTakenE are ignored.
- Transitions:
  - IDLE & MulDivStartE → BUSY, Count = MDU_LATENCY-2.
  - BUSY & Count != 0 → Count decrements.
  - BUSY & Count == 0 → IDLE. No stall is asserted in this cycle, so the mult/div advances at the end of it. MulDivStartE is ignored in this cycle.
- Branch flush (BranchTakenE=1, no MDU stall): FlushD=1, FlushE=1, no stalls.
- Load-use stall (no MDU stall, no branch):
  - Condition: MemReadE & RegWriteE & WriteRegE != 0 & ((UsesRsD & RsD == WriteRegE) | (UsesRtD & RtD == WriteRegE)).
  - Response: StallF=StallD=1 and FlushE=1 for that cycle only; it clears naturally once the bubble enters EX.
- Forwarding is independent of state. Rule for operand A:
  - 10 if RegWriteM & WriteRegM != 0 & WriteRegM == RsE;
  - else 01 if RegWriteW & WriteRegW != 0 & WriteRegW == RsE;
  - else 00.
  - Operand B uses the same rule with RtE.
  - MEM wins when MEM and WB match the same register. Register $0 is never forwarded.

## Timing

- While Rst is high:
  - StallF/D/E=0, FlushD=FlushE=FlushM=1, MduBusy=0, ForwardAE/BE=00.
  - Next state is IDLE, Count=0.
- Rst asserted mid-BUSY aborts the stall; the first cycle after Rst deasserts is IDLE.
- Latencies:
  - Branch and load-use controls are asserted in the same cycle as the condition, with zero-cycle latency.
  - A load-use stall lasts exactly 1 cycle.
  - A mult/div entering EX at cycle t stalls cycles t..t+MDU_LATENCY-2 and leaves EX at the end of cycle t+MDU_LATENCY-1.
  - FlushM is high for exactly those MDU_LATENCY-1 cycles.
- Back-to-back mult/div: the second one reaches EX in the cycle after the BUSY→IDLE transition. It sees IDLE and starts a new full sequence with no gap.
- Load-use hazard pending in ID during BUSY: it is re-evaluated after the stall and produces its own 1-cycle stall then.

## Structure

- Shared package (hazard_pkg):
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - state encoding HZ_IDLE/HZ_BUSY;
  - MDU_CNT_W=4.
- One sub-module: mdu_stall_timer. It contains the IDLE/BUSY FSM and Count, takes MulDivStartE, and outputs the MDU stall. The top level holds the priority mux and the forwarding comparators.

## Test plan

- Load-use: lw $5 in EX (MemReadE=1, WriteRegE=5) with add $6,$5,$2 in ID (RsD=5, UsesRsD=1) → StallF=StallD=FlushE=1 for 1 cycle; next cycle all 0.
- $0 guard:
  - WriteRegE=0 with load and RsD=0 → no stall.
  - WriteRegM=0 with RegWriteM=1 and RsE=0 → ForwardAE=00.
- Forward priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=RsE=7 → ForwardAE=10; with RegWriteM=0 → 01.
- MDU, MDU_LATENCY=4: MulDivStartE held high from cycle t (mult holds EX) → StallF/D/E=FlushM=MduBusy=1 at t, t+1, t+2; all 0 at t+3.
  - Simultaneous BranchTakenE=1 and a load-use match during t..t+2 → FlushD=FlushE=0.
- Branch: BranchTakenE=1 in IDLE together with a load-use match → FlushD=FlushE=1, StallF=StallD=0.
- Reset mid-MDU: Rst=1 at t+1 of a MDU_LATENCY=4 sequence → Flush*=1 and stalls 0 that cycle. With MulDivStartE=0 after reset, outputs are idle; with MulDivStartE=1, a fresh 3-cycle stall starts.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_pkg;

    localparam int MDU_CNT_W = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_e;

    // MEM is the younger producer, so it must win over WB; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src_reg,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src_reg)) begin
            return FWD_MEM;
        end else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src_reg)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/mdu_stall_timer.sv
// rtl/mdu_stall_timer.sv - IDLE/BUSY timer that holds the pipeline while a mult/div occupies EX
module mdu_stall_timer
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mul_div_start,
    output logic mdu_stall
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

    hz_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]  count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The BUSY cycle with count_q == 0 is the release cycle: the op advances and a new start is ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            HZ_IDLE: begin
                if (mul_div_start) begin
                    state_d = HZ_BUSY;
                    count_d = CNT_LOAD;
                end
            end
            HZ_BUSY: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    state_d = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        mdu_stall = 1'b0;
        case (state_q)
            HZ_IDLE: mdu_stall = mul_div_start;
            HZ_BUSY: mdu_stall = (count_q != '0);
            default: mdu_stall = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush priority mux and EX operand forwarding for the 5-stage core
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       UsesRsD,
    input  logic       UsesRtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       MemReadE,
    input  logic       RegWriteE,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteW,
    input  logic       BranchTakenE,
    input  logic       MulDivStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MduBusy
);

    logic mdu_stall;
    logic load_use;

    mdu_stall_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_stall_timer (
        .clk           (Clk),
        .rst           (Rst),
        .mul_div_start (MulDivStartE),
        .mdu_stall     (mdu_stall)
    );

    assign load_use = MemReadE && RegWriteE && (WriteRegE != 5'd0) &&
                      ((UsesRsD && (RsD == WriteRegE)) || (UsesRtD && (RtD == WriteRegE)));

    // While the MDU holds EX, the op must not be bubbled, so EX/MEM receives the bubble instead.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        MduBusy = 1'b0;
        if (Rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (mdu_stall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            FlushM  = 1'b1;
            MduBusy = 1'b1;
        end else if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!Rst) begin
            ForwardAE = fwd_select(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_select(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized self-checking bench against a cycle-window reference model
module tb_hazard_control_unit;

    localparam int LAT = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       UsesRsD, UsesRtD, MemReadE, RegWriteE, RegWriteM, RegWriteW;
    logic       BranchTakenE, MulDivStartE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;
    logic [1:0] ForwardAE, ForwardBE;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int win_end   = -1;
    int rel_cycle = -1;

    always #5 Clk = ~Clk;

    hazard_control_unit #(
        .MDU_LATENCY (LAT)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .RsD          (RsD),
        .RtD          (RtD),
        .UsesRsD      (UsesRsD),
        .UsesRtD      (UsesRtD),
        .RsE          (RsE),
        .RtE          (RtE),
        .WriteRegE    (WriteRegE),
        .MemReadE     (MemReadE),
        .RegWriteE    (RegWriteE),
        .WriteRegM    (WriteRegM),
        .RegWriteM    (RegWriteM),
        .WriteRegW    (WriteRegW),
        .RegWriteW    (RegWriteW),
        .BranchTakenE (BranchTakenE),
        .MulDivStartE (MulDivStartE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .MduBusy      (MduBusy)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src) return 2'b10;
        if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        UsesRsD = 0; UsesRtD = 0; MemReadE = 0; RegWriteE = 0;
        RegWriteM = 0; RegWriteW = 0; BranchTakenE = 0; MulDivStartE = 0;
    endtask

    // Model: a mult/div starting in cycle t stalls t..t+LAT-2 and is released (start ignored) at t+LAT-1.
    task automatic run_cycle();
        logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_busy;
        logic [1:0] e_fa, e_fb;
        bit in_win, mdu, lu;
        @(negedge Clk);
        e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0; e_busy = 0;
        e_fa = 2'b00; e_fb = 2'b00;
        if (Rst) begin
            e_fd = 1; e_fe = 1; e_fm = 1;
            win_end   = -1;
            rel_cycle = -1;
        end else begin
            in_win = (cyc <= win_end);
            mdu    = in_win || (MulDivStartE && cyc != rel_cycle);
            lu     = MemReadE && RegWriteE && WriteRegE != 0 &&
                     ((UsesRsD && RsD == WriteRegE) || (UsesRtD && RtD == WriteRegE));
            e_fa = ref_fwd(RsE);
            e_fb = ref_fwd(RtE);
            if (mdu) begin
                e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1; e_busy = 1;
                if (!in_win) begin
                    win_end   = cyc + LAT - 2;
                    rel_cycle = cyc + LAT - 1;
                end
            end else if (BranchTakenE) begin
                e_fd = 1; e_fe = 1;
            end else if (lu) begin
                e_sf = 1; e_sd = 1; e_fe = 1;
            end
        end
        check_eq("stall_f",  8'(StallF),    8'(e_sf));
        check_eq("stall_d",  8'(StallD),    8'(e_sd));
        check_eq("stall_e",  8'(StallE),    8'(e_se));
        check_eq("flush_d",  8'(FlushD),    8'(e_fd));
        check_eq("flush_e",  8'(FlushE),    8'(e_fe));
        check_eq("flush_m",  8'(FlushM),    8'(e_fm));
        check_eq("mdu_busy", 8'(MduBusy),   8'(e_busy));
        check_eq("fwd_a",    8'(ForwardAE), 8'(e_fa));
        check_eq("fwd_b",    8'(ForwardBE), 8'(e_fb));
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_load_use();
        MemReadE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; UsesRsD = 1;
    endtask

    initial begin
        clr_inputs();
        Rst = 1;
        @(posedge Clk);
        #1;
        run_cycle();
        run_cycle();
        Rst = 0;
        run_cycle();

        set_load_use();
        run_cycle();
        clr_inputs();
        run_cycle();

        MemReadE = 1; RegWriteE = 1; WriteRegE = 0; RsD = 0; UsesRsD = 1;
        run_cycle();
        clr_inputs();
        RegWriteM = 1; WriteRegM = 0; RsE = 0;
        run_cycle();

        RegWriteM = 1; RegWriteW = 1; WriteRegM = 7; WriteRegW = 7; RsE = 7; RtE = 7;
        run_cycle();
        RegWriteM = 0;
        run_cycle();
        clr_inputs();

        MulDivStartE = 1;
        for (int i = 0; i < LAT - 1; i++) begin
            BranchTakenE = 1;
            set_load_use();
            run_cycle();
        end
        clr_inputs();
        MulDivStartE = 1;
        run_cycle();
        clr_inputs();
        run_cycle();

        BranchTakenE = 1;
        set_load_use();
        run_cycle();
        clr_inputs();

        MulDivStartE = 1;
        run_cycle();
        Rst = 1;
        run_cycle();
        Rst = 0;
        MulDivStartE = 0;
        run_cycle();
        MulDivStartE = 1;
        for (int i = 0; i < LAT + 2; i++) run_cycle();

        MulDivStartE = 1;
        for (int i = 0; i < 2 * LAT; i++) run_cycle();
        clr_inputs();
        run_cycle();

        for (int i = 0; i < 700; i++) begin
            Rst          = ($urandom_range(0, 59) == 0);
            RsD          = 5'($urandom_range(0, 3));
            RtD          = 5'($urandom_range(0, 3));
            RsE          = 5'($urandom_range(0, 3));
            RtE          = 5'($urandom_range(0, 3));
            WriteRegE    = 5'($urandom_range(0, 3));
            WriteRegM    = 5'($urandom_range(0, 3));
            WriteRegW    = 5'($urandom_range(0, 3));
            UsesRsD      = 1'($urandom_range(0, 1));
            UsesRtD      = 1'($urandom_range(0, 1));
            MemReadE     = 1'($urandom_range(0, 1));
            RegWriteE    = ($urandom_range(0, 3) != 0);
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            BranchTakenE = ($urandom_range(0, 4) == 0);
            MulDivStartE = ($urandom_range(0, 5) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
